// File: rtl/afe_ro_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afe_ro_pkg
// Description : Shared types and helpers for the AFE readout buffer
//               controller: buffer depth helper, default pointer/fill types
//               and the per-cycle SRAM access decision encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package afe_ro_pkg;

    // Default geometry. Parameterised instances derive their own widths
    // from ADDR_WIDTH through afe_ro_depth().
    localparam int AFE_RO_ADDR_WIDTH = 10;
    localparam int AFE_RO_DEPTH      = 2 ** AFE_RO_ADDR_WIDTH;

    typedef logic [AFE_RO_ADDR_WIDTH-1:0] afe_ro_ptr_t;
    typedef logic [AFE_RO_ADDR_WIDTH:0]   afe_ro_fill_t;

    // One decision per cycle, listed in priority order.
    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        WRITE = 3'd1,
        DROP  = 3'd2,
        READ  = 3'd3,
        IDLE  = 3'd4
    } afe_ro_dec_e;

    // Buffer depth for a given SRAM address width.
    function automatic int afe_ro_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/afe_ro_buf_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : afe_ro_buf_ctrl_if
// Description : Single-port readout SRAM bus (active-low CEN/WEN, 1-cycle
//               read latency).
//               master : controller side (drives cen/wen/addr/wdata)
//               slave  : memory side (returns rdata)
// Revision    : 1.0 - initial release
// ============================================================================
interface afe_ro_buf_ctrl_if #(
    parameter int AFE_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 10
) ();

    logic                      sram_cen;
    logic                      sram_wen;
    logic [ADDR_WIDTH-1:0]     sram_addr;
    logic [AFE_DATA_WIDTH-1:0] sram_wdata;
    logic [AFE_DATA_WIDTH-1:0] sram_rdata;

    modport master (
        output sram_cen,
        output sram_wen,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_cen,
        input  sram_wen,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );

endinterface
`default_nettype wire

// File: rtl/afe_ro_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : afe_ro_sat_cnt
// Description : Up-counter that sticks at all-ones, with synchronous clear.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   clear_i : synchronous clear (wins over inc_i)
//   inc_i   : increment request
//   cnt_o   : current count
// Revision    : 1.0 - initial release
// ============================================================================
module afe_ro_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             clear_i,
    input  wire logic             inc_i,
    output logic      [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/afe_ro_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : afe_ro_buf_ctrl
// Description : Writes the non-stallable AFE sample stream into a single-port
//               SRAM used as a circular FIFO and serves a host read
//               request/grant port. Writes always win the single SRAM slot.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   clear_i           : synchronous flush of pointers, fill, flags, counters
//   afe_valid_i/data  : sample strobe and sample
//   rd_req_i          : host read request
//   rd_gnt_o          : read accepted this cycle
//   rd_valid_o/data_o : read data, one cycle after the grant
//   wm_i / irq_wm_o   : watermark level / one-cycle crossing pulse
//   fill_o, empty_o, full_o, overflow_o, drop_cnt_o : status
//   sram              : SRAM bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module afe_ro_buf_ctrl
    import afe_ro_pkg::*;
#(
    parameter int AFE_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  wire logic                      clk_i,
    input  wire logic                      rst_i,
    input  wire logic                      clear_i,
    input  wire logic                      afe_valid_i,
    input  wire logic [AFE_DATA_WIDTH-1:0] afe_data_i,
    input  wire logic                      rd_req_i,
    output logic                           rd_gnt_o,
    output logic                           rd_valid_o,
    output logic      [AFE_DATA_WIDTH-1:0] rd_data_o,
    input  wire logic [ADDR_WIDTH:0]       wm_i,
    output logic                           irq_wm_o,
    output logic      [ADDR_WIDTH:0]       fill_o,
    output logic                           empty_o,
    output logic                           full_o,
    output logic                           overflow_o,
    output logic      [DROP_CNT_WIDTH-1:0] drop_cnt_o,
    afe_ro_buf_ctrl_if.master              sram
);

    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH+1)'(afe_ro_depth(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH:0]   FILL_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    afe_ro_dec_e             dec;

    logic [ADDR_WIDTH-1:0]   wptr_d, wptr_q;
    logic [ADDR_WIDTH-1:0]   rptr_d, rptr_q;
    logic [ADDR_WIDTH:0]     fill_d, fill_q;
    logic                    ovf_d, ovf_q;
    logic                    irq_d, irq_q;
    logic                    rd_valid_d, rd_valid_q;
    logic                    empty;
    logic                    full;

    assign empty = (fill_q == '0);
    assign full  = (fill_q == FULL_LEVEL);

    // Per-cycle decision. Reset forces IDLE so the combinational SRAM
    // controls fall back to their reset values immediately, without
    // waiting for a clock edge.
    always_comb begin
        dec = IDLE;
        if (rst_i) begin
            dec = IDLE;
        end else if (clear_i) begin
            dec = CLEAR;
        end else if (afe_valid_i) begin
            // A sample always claims the cycle; a pending read waits even
            // when the sample itself has to be dropped.
            dec = full ? DROP : WRITE;
        end else if (rd_req_i && !empty) begin
            dec = READ;
        end
    end

    always_comb begin
        sram.sram_cen   = 1'b1;
        sram.sram_wen   = 1'b1;
        sram.sram_addr  = '0;
        sram.sram_wdata = '0;
        case (dec)
            WRITE: begin
                sram.sram_cen   = 1'b0;
                sram.sram_wen   = 1'b0;
                sram.sram_addr  = wptr_q;
                sram.sram_wdata = afe_data_i;
            end
            READ: begin
                sram.sram_cen   = 1'b0;
                sram.sram_addr  = rptr_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fill_d     = fill_q;
        ovf_d      = ovf_q;
        irq_d      = 1'b0;
        rd_valid_d = 1'b0;
        case (dec)
            CLEAR: begin
                wptr_d = '0;
                rptr_d = '0;
                fill_d = '0;
                ovf_d  = 1'b0;
            end
            WRITE: begin
                // Pointers are exactly ADDR_WIDTH bits, so D-1 wraps to 0.
                wptr_d = wptr_q + PTR_ONE;
                fill_d = fill_q + FILL_ONE;
                // Crossing from wm-1 to wm; a zero watermark never fires.
                irq_d  = (wm_i != '0) && ((fill_q + FILL_ONE) == wm_i);
            end
            DROP: begin
                ovf_d = 1'b1;
            end
            READ: begin
                rptr_d     = rptr_q + PTR_ONE;
                fill_d     = fill_q - FILL_ONE;
                rd_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fill_q     <= '0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fill_q     <= fill_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    afe_ro_sat_cnt #(
        .WIDTH (DROP_CNT_WIDTH)
    ) u_drop_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (dec == CLEAR),
        .inc_i   (dec == DROP),
        .cnt_o   (drop_cnt_o)
    );

    assign rd_gnt_o   = (dec == READ);
    // A flush in the cycle the data returns discards that data.
    assign rd_valid_o = rd_valid_q & ~clear_i;
    assign rd_data_o  = sram.sram_rdata;
    assign irq_wm_o   = irq_q;
    assign fill_o     = fill_q;
    assign empty_o    = empty;
    assign full_o     = full;
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_afe_ro_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_afe_ro_buf_ctrl
// Description : Self-checking bench for afe_ro_buf_ctrl with a behavioural
//               SRAM and a queue-based reference FIFO / read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afe_ro_buf_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DCW   = 16;
    localparam int DEPTH = 16;

    localparam int D_CLR  = 0;
    localparam int D_WR   = 1;
    localparam int D_DROP = 2;
    localparam int D_RD   = 3;
    localparam int D_IDLE = 4;

    logic          clk         = 1'b0;
    logic          rst_i       = 1'b1;
    logic          clear_i     = 1'b0;
    logic          afe_valid_i = 1'b0;
    logic [DW-1:0] afe_data_i  = '0;
    logic          rd_req_i    = 1'b0;
    logic [AW:0]   wm_i        = '0;

    logic           rd_gnt_o;
    logic           rd_valid_o;
    logic [DW-1:0]  rd_data_o;
    logic           irq_wm_o;
    logic [AW:0]    fill_o;
    logic           empty_o;
    logic           full_o;
    logic           overflow_o;
    logic [DCW-1:0] drop_cnt_o;

    afe_ro_buf_ctrl_if #(.AFE_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sram_if ();

    afe_ro_buf_ctrl #(
        .AFE_DATA_WIDTH (DW),
        .ADDR_WIDTH     (AW),
        .DROP_CNT_WIDTH (DCW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .afe_valid_i (afe_valid_i),
        .afe_data_i  (afe_data_i),
        .rd_req_i    (rd_req_i),
        .rd_gnt_o    (rd_gnt_o),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .wm_i        (wm_i),
        .irq_wm_o    (irq_wm_o),
        .fill_o      (fill_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .overflow_o  (overflow_o),
        .drop_cnt_o  (drop_cnt_o),
        .sram        (sram_if.master)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM, 1-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q = '0;
    always @(posedge clk) begin
        if (!sram_if.sram_cen) begin
            if (!sram_if.sram_wen) mem[sram_if.sram_addr] <= sram_if.sram_wdata;
            else                   rdata_q <= mem[sram_if.sram_addr];
        end
    end
    assign sram_if.sram_rdata = rdata_q;

    // Reference model
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_rd[$];
    logic [AW-1:0] m_wptr = '0;
    logic [AW-1:0] m_rptr = '0;
    bit            m_ovf  = 1'b0;
    int            m_drop = 0;
    bit            pend_valid = 1'b0;
    bit            pend_irq   = 1'b0;

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_rd.delete();
        m_wptr     = '0;
        m_rptr     = '0;
        m_ovf      = 1'b0;
        m_drop     = 0;
        pend_valid = 1'b0;
        pend_irq   = 1'b0;
    endtask

    task automatic check_status();
        chk("fill",     32'(fill_o),     32'(m_q.size()));
        chk("empty",    32'(empty_o),    32'(m_q.size() == 0));
        chk("full",     32'(full_o),     32'(m_q.size() == DEPTH));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
    endtask

    // One clock cycle: drive inputs just after a rising edge, check at the
    // falling edge, then advance the model with this cycle's decision.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit req, input bit clr);
        int            dec;
        bit            exp_valid;
        logic [DW-1:0] e;
        afe_valid_i = v;
        afe_data_i  = d;
        rd_req_i    = req;
        clear_i     = clr;
        if (clr)                           dec = D_CLR;
        else if (v && m_q.size() < DEPTH)  dec = D_WR;
        else if (v)                        dec = D_DROP;
        else if (req && m_q.size() > 0)    dec = D_RD;
        else                               dec = D_IDLE;

        @(negedge clk);
        chk("rd_gnt",   32'(rd_gnt_o),         32'(dec == D_RD));
        chk("sram_cen", 32'(sram_if.sram_cen), 32'(!(dec == D_WR || dec == D_RD)));
        chk("sram_wen", 32'(sram_if.sram_wen), 32'(dec != D_WR));
        if (dec == D_WR) begin
            chk("wr_addr", 32'(sram_if.sram_addr),  32'(m_wptr));
            chk("wr_data", 32'(sram_if.sram_wdata), 32'(d));
        end
        if (dec == D_RD) chk("rd_addr", 32'(sram_if.sram_addr), 32'(m_rptr));
        exp_valid = pend_valid && !clr;
        chk("rd_valid", 32'(rd_valid_o), 32'(exp_valid));
        if (pend_valid) begin
            e = exp_rd.pop_front();
            if (exp_valid) chk("rd_data", 32'(rd_data_o), 32'(e));
        end
        chk("irq_wm", 32'(irq_wm_o), 32'(pend_irq));
        check_status();

        pend_valid = (dec == D_RD);
        pend_irq   = (dec == D_WR) && (wm_i != '0) && ((m_q.size() + 1) == int'(wm_i));
        case (dec)
            D_CLR: begin
                m_q.delete();
                m_wptr = '0;
                m_rptr = '0;
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            D_WR: begin
                m_q.push_back(d);
                m_wptr = m_wptr + 1'b1;
            end
            D_DROP: begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
            D_RD: begin
                exp_rd.push_back(m_q.pop_front());
                m_rptr = m_rptr + 1'b1;
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_cen",   32'(sram_if.sram_cen),   32'(1));
        chk("rst_wen",   32'(sram_if.sram_wen),   32'(1));
        chk("rst_addr",  32'(sram_if.sram_addr),  32'(0));
        chk("rst_wdata", 32'(sram_if.sram_wdata), 32'(0));
        chk("rst_gnt",   32'(rd_gnt_o),           32'(0));
        chk("rst_valid", 32'(rd_valid_o),         32'(0));
        chk("rst_irq",   32'(irq_wm_o),           32'(0));
        check_status();
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Basic write then streamed read
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'hA000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Fill to full, drop two, read back the first sixteen
        for (int i = 0; i < 18; i++) step(1'b1, 16'(16'hB000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Write beats a simultaneous read request
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hC000 + i), 1'b0, 1'b0);
        step(1'b1, 16'hC003, 1'b1, 1'b0);
        step(1'b1, 16'hC004, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Watermark crossings
        wm_i = 5'd4;
        for (int i = 0; i < 6; i++) step(1'b1, 16'(16'hD000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'hD006, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'hD007, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        wm_i = '0;

        // Alternating write/read across the address wrap
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'(16'hE000 + i), 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0);

        // Flush in the cycle after a grant
        step(1'b1, 16'h5A01, 1'b0, 1'b0);
        step(1'b1, 16'h5A02, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-burst with fill=7 and a read in flight
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h7000 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        afe_valid_i = 1'b1;
        afe_data_i  = 16'h7777;
        rd_req_i    = 1'b1;
        #1;
        rst_i = 1'b1;
        #1;
        model_reset();
        chk("arst_cen",   32'(sram_if.sram_cen),   32'(1));
        chk("arst_wen",   32'(sram_if.sram_wen),   32'(1));
        chk("arst_addr",  32'(sram_if.sram_addr),  32'(0));
        chk("arst_wdata", 32'(sram_if.sram_wdata), 32'(0));
        chk("arst_gnt",   32'(rd_gnt_o),           32'(0));
        chk("arst_valid", 32'(rd_valid_o),         32'(0));
        check_status();
        @(posedge clk);
        #1;
        rst_i       = 1'b0;
        afe_valid_i = 1'b0;
        rd_req_i    = 1'b0;
        step(1'b1, 16'hF0F0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
